dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra wait cycles per access (0..15).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port dm_req  input  1  access request valid, held by requester until dm_ready.
REQ-006 SHALL have port dm_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port dm_funct3  input  3  RV32I size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 SHALL have port dm_addr  input  32  byte address (datapath ALU result).
REQ-009 SHALL have port dm_wdata  input  32  store data (datapath rs2 value).
REQ-010 SHALL have port dm_rdata  output  32  load result, sign/zero-extended, to writeback mux.
REQ-011 SHALL have port dm_ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port dm_stall  output  1  pipeline freeze request.
REQ-013 SHALL have port dm_fault  output  1  one-cycle pulse with dm_ready on a faulted access.

Function
REQ-014 SHALL implement FSM IDLE, WAIT, DONE; IDLE+dm_req -> WAIT if WAIT_CYCLES>0, else -> DONE; WAIT -> DONE when down-counter reaches 0; DONE -> IDLE unconditionally.
REQ-015 SHALL latch we/funct3/addr/wdata on acceptance in IDLE; later input changes SHALL not affect the access.
REQ-016 SHALL load the wait counter with WAIT_CYCLES-1 on acceptance and decrement once per WAIT cycle; latency acceptance-to-dm_ready = WAIT_CYCLES+1 cycles.
REQ-017 SHALL drive dm_stall = (IDLE and dm_req) or WAIT, combinationally; low in DONE.
REQ-018 SHALL assert dm_ready only during DONE; dm_req in DONE SHALL be ignored (next acceptance earliest in the following IDLE).
REQ-019 SHALL perform the store on the clock edge entering DONE, byte lanes: SB lane addr[1:0], SH lanes addr[1]*2..+1, SW all four; unselected bytes unchanged.
REQ-020 SHALL register dm_rdata on the edge entering DONE and hold it until the next load completes; store completion SHALL not change dm_rdata.
REQ-021 SHALL extract loads: LB/LH sign-extend, LBU/LHU zero-extend, lane selected by addr[1:0].
REQ-022 SHALL fault (no memory write, dm_rdata unchanged, dm_fault with dm_ready) on LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, or funct3 011/110/111 (either direction).
REQ-023 SHALL index storage with addr[log2(DEPTH_WORDS)+1:2]; upper address bits ignored (aliasing wrap-around).
REQ-024 SHALL return newly stored data to a load issued after a store to the same word completes.

Reset
REQ-025 SHALL on rst force state IDLE, counter 0, dm_rdata 0, dm_ready 0, dm_fault 0; dm_stall follows dm_req.
REQ-026 SHALL abandon an in-flight access on rst; a store not yet at DONE SHALL not be written.
REQ-027 SHALL not reset storage contents.

Structure
REQ-028 SHALL place funct3 encodings, FSM state encoding and counter width constant in shared package dmem_pkg.
REQ-029 SHALL use one combinational sub-module dmem_lane_fmt (store byte-mask/data replication, load extraction/extension).

Verification
REQ-030 SW 0xDEADBEEF @0x10, then LW @0x10 -> dm_rdata=0xDEADBEEF, dm_ready 2 cycles after each acceptance (WAIT_CYCLES=1).
REQ-031 After REQ-030: SB 0x7F @0x13, LB @0x13 -> 0x0000007F; LBU @0x12 -> 0x000000AD; LB @0x12 -> 0xFFFFFFAD; LH @0x12 -> 0x00007FAD.
REQ-032 LW @0x12 and SH @0x11 -> dm_fault and dm_ready same cycle, memory @0x10 unchanged, dm_rdata unchanged.
REQ-033 WAIT_CYCLES=3: dm_stall high 4 cycles from acceptance, dm_ready on 5th; WAIT_CYCLES=0: dm_ready cycle after acceptance.
REQ-034 SW 0x1234 @0x40, rst pulsed during WAIT -> FSM IDLE, dm_ready never pulses, later LW @0x40 returns prior content.
REQ-035 DEPTH_WORDS=1024: SW 0xA5A5A5A5 @0x1000, LW @0x0 -> 0xA5A5A5A5 (alias).

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM encoding and wait-counter width for the data memory controller
package dmem_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam int CNT_W = 4;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between the pipeline and the data memory controller
interface dmem_if;
   logic        dm_req;
   logic        dm_we;
   logic [2:0]  dm_funct3;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        dm_stall;
   logic        dm_fault;
   modport master (output dm_req, dm_we, dm_funct3, dm_addr, dm_wdata,
                   input  dm_rdata, dm_ready, dm_stall, dm_fault);
   modport slave  (input  dm_req, dm_we, dm_funct3, dm_addr, dm_wdata,
                   output dm_rdata, dm_ready, dm_stall, dm_fault);
endinterface

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: store byte-enable/replication, load lane extraction/extension and alignment fault
module dmem_lane_fmt
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] word,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext,
   output logic        fault
);
   logic [1:0]  size;
   logic [31:0] shifted;
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      size      = funct3[1:0];
      shifted   = word >> {off, 3'b000};
      b         = shifted[7:0];
      h         = off[1] ? word[31:16] : word[15:0];
      be        = size == 2'd0 ? 4'b0001 << off : size == 2'd1 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata_rep = size == 2'd0 ? {4{wdata[7:0]}} : size == 2'd1 ? {2{wdata[15:0]}} : wdata;
      rdata_ext = funct3 == F3_B  ? {{24{b[7]}}, b} :
                  funct3 == F3_BU ? {24'b0, b} :
                  funct3 == F3_H  ? {{16{h[15]}}, h} :
                  funct3 == F3_HU ? {16'b0, h} : word;
      // 011 and 11x are unused encodings in both directions
      fault     = size == 2'd3 || funct3[2:1] == 2'b11 ||
                  (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'b00);
   end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: wait-stated RV32I data memory with byte lanes, alignment faults and pipeline stall
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input logic   clk,
   input logic   rst,
   dmem_if.slave dm
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt;
   logic              we_q, fault_q;
   logic [2:0]        f3_q;
   logic [AW+1:0]     addr_q;
   logic [31:0]       wdata_q, rdata_q;
   logic [31:0]       mem [DEPTH_WORDS];
   logic              accept, enter_done, cur_we;
   logic [2:0]        cur_f3;
   logic [AW+1:0]     cur_addr;
   logic [31:0]       cur_wdata, word;
   logic [3:0]        be;
   logic [31:0]       wdata_rep, rdata_ext;
   logic              fault;
   // In IDLE the live bus is used so a zero-wait access can complete on its acceptance edge
   always_comb begin
      accept     = state == S_IDLE && dm.dm_req;
      cur_we     = state == S_IDLE ? dm.dm_we : we_q;
      cur_f3     = state == S_IDLE ? dm.dm_funct3 : f3_q;
      cur_addr   = state == S_IDLE ? dm.dm_addr[AW+1:0] : addr_q;
      cur_wdata  = state == S_IDLE ? dm.dm_wdata : wdata_q;
      word       = mem[cur_addr[AW+1:2]];
      enter_done = state_n == S_DONE;
   end
   dmem_lane_fmt u_fmt (
      .funct3    (cur_f3),
      .off       (cur_addr[1:0]),
      .wdata     (cur_wdata),
      .word      (word),
      .be        (be),
      .wdata_rep (wdata_rep),
      .rdata_ext (rdata_ext),
      .fault     (fault)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         f3_q    <= 3'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            cnt     <= CNT_INIT;
            we_q    <= dm.dm_we;
            f3_q    <= dm.dm_funct3;
            addr_q  <= dm.dm_addr[AW+1:0];
            wdata_q <= dm.dm_wdata;
         end else if (state == S_WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (enter_done) begin
            fault_q <= fault;
            if (!cur_we && !fault) rdata_q <= rdata_ext;
         end
      end
   end
   // Storage is deliberately outside the reset domain
   always_ff @(posedge clk) begin
      if (enter_done && cur_we && !fault)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[cur_addr[AW+1:2]][8*i +: 8] <= wdata_rep[8*i +: 8];
   end
   always_comb begin
      state_n = state == S_IDLE ? (dm.dm_req ? (WAIT_CYCLES > 0 ? S_WAIT : S_DONE) : S_IDLE) :
                state == S_WAIT ? (cnt == '0 ? S_DONE : S_WAIT) : S_IDLE;
   end
   always_comb begin
      dm.dm_stall = (state == S_IDLE && dm.dm_req) || state == S_WAIT;
      dm.dm_ready = state == S_DONE;
      dm.dm_fault = state == S_DONE && fault_q;
      dm.dm_rdata = rdata_q;
   end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed scoreboard bench for dmem_ctrl at WAIT_CYCLES 1, 3 and 0
module tb_dmem_ctrl;
   import dmem_pkg::*;
   typedef struct {logic [31:0] rd; logic f; int lat;} exp_t;
   logic        clk, rst;
   logic        req [3];
   logic        we;
   logic [2:0]  f3;
   logic [31:0] addr, wdata;
   logic        rdy [3], stl [3], flt [3];
   logic [31:0] rd [3];
   int          waits [3] = '{1, 3, 0};
   int          checks = 0, failures = 0;
   exp_t        q [$];
   dmem_if b0 (), b1 (), b2 ();
   dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u0 (.clk(clk), .rst(rst), .dm(b0));
   dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u1 (.clk(clk), .rst(rst), .dm(b1));
   dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u2 (.clk(clk), .rst(rst), .dm(b2));
   assign b0.dm_req = req[0];
   assign b1.dm_req = req[1];
   assign b2.dm_req = req[2];
   assign b0.dm_we = we;
   assign b1.dm_we = we;
   assign b2.dm_we = we;
   assign b0.dm_funct3 = f3;
   assign b1.dm_funct3 = f3;
   assign b2.dm_funct3 = f3;
   assign b0.dm_addr = addr;
   assign b1.dm_addr = addr;
   assign b2.dm_addr = addr;
   assign b0.dm_wdata = wdata;
   assign b1.dm_wdata = wdata;
   assign b2.dm_wdata = wdata;
   assign rdy[0] = b0.dm_ready;
   assign rdy[1] = b1.dm_ready;
   assign rdy[2] = b2.dm_ready;
   assign stl[0] = b0.dm_stall;
   assign stl[1] = b1.dm_stall;
   assign stl[2] = b2.dm_stall;
   assign flt[0] = b0.dm_fault;
   assign flt[1] = b1.dm_fault;
   assign flt[2] = b2.dm_fault;
   assign rd[0] = b0.dm_rdata;
   assign rd[1] = b1.dm_rdata;
   assign rd[2] = b2.dm_rdata;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // Drive one access, push its expectation, then pop and compare when dm_ready arrives
   task automatic access(input int k, input string tag, input logic w, input logic [2:0] fn,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_f);
      exp_t e;
      int   lat;
      @(negedge clk);
      we = w; f3 = fn; addr = a; wdata = d; req[k] = 1'b1;
      q.push_back('{exp_rd, exp_f, waits[k] + 1});
      #1 check({tag, ":stall_acc"}, 32'(stl[k]), 32'd1);
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
         if (lat == 1) begin
            we = ~w; f3 = F3_W; addr = ~a; wdata = ~d;
         end
         if (!rdy[k]) check({tag, ":stall_wait"}, 32'(stl[k]), 32'd1);
      end while (!rdy[k] && lat < 40);
      req[k] = 1'b0;
      e = q.pop_front();
      check({tag, ":ready"}, 32'(rdy[k]), 32'd1);
      check({tag, ":latency"}, 32'(lat), 32'(e.lat));
      check({tag, ":fault"}, 32'(flt[k]), 32'(e.f));
      check({tag, ":rdata"}, rd[k], e.rd);
      check({tag, ":stall_done"}, 32'(stl[k]), 32'd0);
      @(posedge clk);
      #1 check({tag, ":ready_pulse"}, 32'(rdy[k]), 32'd0);
      check({tag, ":fault_pulse"}, 32'(flt[k]), 32'd0);
   endtask
   initial begin
      rst = 1'b1; we = 1'b0; f3 = 3'b0; addr = '0; wdata = '0;
      for (int i = 0; i < 3; i++) req[i] = 1'b0;
      @(negedge clk);
      check("rst_rdata", rd[0], 32'd0);
      check("rst_ready", 32'(rdy[0]), 32'd0);
      check("rst_fault", 32'(flt[0]), 32'd0);
      check("rst_stall_lo", 32'(stl[0]), 32'd0);
      req[0] = 1'b1;
      #1 check("rst_stall_follow", 32'(stl[0]), 32'd1);
      req[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      access(0, "sw10",   1'b1, F3_W,   32'h10,   32'hDEADBEEF, 32'h0,        1'b0);
      access(0, "lw10",   1'b0, F3_W,   32'h10,   32'h0,        32'hDEADBEEF, 1'b0);
      access(0, "sb13",   1'b1, F3_B,   32'h13,   32'h0000007F, 32'hDEADBEEF, 1'b0);
      access(0, "lb13",   1'b0, F3_B,   32'h13,   32'h0,        32'h0000007F, 1'b0);
      access(0, "lbu12",  1'b0, F3_BU,  32'h12,   32'h0,        32'h000000AD, 1'b0);
      access(0, "lb12",   1'b0, F3_B,   32'h12,   32'h0,        32'hFFFFFFAD, 1'b0);
      access(0, "lh12",   1'b0, F3_H,   32'h12,   32'h0,        32'h00007FAD, 1'b0);
      access(0, "lw12f",  1'b0, F3_W,   32'h12,   32'h0,        32'h00007FAD, 1'b1);
      access(0, "sh11f",  1'b1, F3_H,   32'h11,   32'hFFFF,     32'h00007FAD, 1'b1);
      access(0, "lw10b",  1'b0, F3_W,   32'h10,   32'h0,        32'h7FADBEEF, 1'b0);
      access(0, "lhu10",  1'b0, F3_HU,  32'h10,   32'h0,        32'h0000BEEF, 1'b0);
      access(0, "lh10",   1'b0, F3_H,   32'h10,   32'h0,        32'hFFFFBEEF, 1'b0);
      access(0, "ld011f", 1'b0, 3'b011, 32'h10,   32'h0,        32'hFFFFBEEF, 1'b1);
      access(0, "sw110f", 1'b1, 3'b110, 32'h10,   32'h0,        32'hFFFFBEEF, 1'b1);
      access(0, "sh12",   1'b1, F3_H,   32'h12,   32'h1234,     32'hFFFFBEEF, 1'b0);
      access(0, "lw10c",  1'b0, F3_W,   32'h10,   32'h0,        32'h1234BEEF, 1'b0);
      access(0, "sw1000", 1'b1, F3_W,   32'h1000, 32'hA5A5A5A5, 32'h1234BEEF, 1'b0);
      access(0, "lw0",    1'b0, F3_W,   32'h0,    32'h0,        32'hA5A5A5A5, 1'b0);
      access(0, "sw40",   1'b1, F3_W,   32'h40,   32'h55,       32'hA5A5A5A5, 1'b0);
      access(1, "w3_sw",  1'b1, F3_W,   32'h20,   32'hCAFEF00D, 32'h0,        1'b0);
      access(1, "w3_lw",  1'b0, F3_W,   32'h20,   32'h0,        32'hCAFEF00D, 1'b0);
      access(2, "w0_sw",  1'b1, F3_W,   32'h24,   32'h11223344, 32'h0,        1'b0);
      access(2, "w0_lbu", 1'b0, F3_BU,  32'h25,   32'h0,        32'h00000033, 1'b0);
      @(negedge clk);
      we = 1'b1; f3 = F3_W; addr = 32'h40; wdata = 32'h1234; req[0] = 1'b1;
      @(posedge clk);
      #1 check("rstw_stall_wait", 32'(stl[0]), 32'd1);
      check("rstw_ready_wait", 32'(rdy[0]), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1 check("rstw_ready", 32'(rdy[0]), 32'd0);
      check("rstw_stall_req", 32'(stl[0]), 32'd1);
      check("rstw_rdata", rd[0], 32'd0);
      req[0] = 1'b0;
      #1 check("rstw_stall_idle", 32'(stl[0]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 check("rstw_no_ready", 32'(rdy[0]), 32'd0);
      end
      access(0, "lw40", 1'b0, F3_W, 32'h40, 32'h0, 32'h00000055, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
